seq_muldiv_unit: RTL and testbench
==================================

# seq_muldiv_unit

Parametrised multicycle multiply/divide unit for the datapath's Hi/Lo path. It replaces the fixed 32-bit mult/div block. It adds:
- a start/busy/done handshake
- signed and unsigned modes for both operations
- a WIDTH parameter
- a deterministic divide-by-zero exit

Operands come from registers A/B. The hi/lo outputs feed the Hi and Lo registers, and the control unit stalls on busy.

## Interface

Parameters:
- WIDTH, 32, operand width; legal values 4..64.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  in  1  request; accepted only when the FSM is in IDLE.
- op  in  2  operation select, sampled on accept: 00 signed mult, 01 unsigned mult, 10 signed div, 11 unsigned div.
- a  in  WIDTH  multiplicand / dividend, sampled on accept.
- b  in  WIDTH  multiplier / divisor, sampled on accept.
- busy  out  1  high while an accepted operation is in progress.
- done  out  1  one-cycle pulse; hi/lo/div_zero are final in this cycle.
- hi  out  WIDTH  product upper half, or remainder.
- lo  out  WIDTH  product lower half, or quotient.
- div_zero  out  1  set at completion of a divide with b==0.

## Operation

- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE: when start=1, latch op, a and b; clear div_zero; go to PREP. Otherwise stay in IDLE.
- PREP: in signed modes, record the operand signs and convert both operands to magnitudes. Load the iteration counter with WIDTH.
  - If op is a divide and b==0, go to DONE with div_zero=1. Skip CALC and FIX.
  - Otherwise go to CALC.
- CALC: run one iteration per cycle, then decrement the counter. Go to FIX when the counter reaches 0.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- FIX: apply sign correction, then register the results into hi/lo. Go to DONE.
  - Multiply: negate the product if the operand signs differ.
  - Divide: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Result rules:
  - Multiply: {hi,lo} is the exact 2*WIDTH-bit product in the selected signedness.
  - Divide: the quotient truncates toward zero and a == lo*b + hi.
  - Signed divide of MIN by -1: lo=MIN (wraps), hi=0, no flag.
- Divide by zero: hi and lo keep their previous values and div_zero=1.
- hi, lo and div_zero hold their values until the next completing operation. div_zero also clears when a new start is accepted.
- start while busy, or in the DONE cycle, is ignored. No queueing.
- Changes to a, b or op after accept do not affect the result.
- Reset in any state: at the next edge the FSM goes to IDLE, hi=0, lo=0, div_zero=0, done=0, busy=0. The in-flight operation is discarded with no done pulse.

## Timing

- Cycle 0 is the cycle where start=1 with the FSM in IDLE. It is accepted at the end of cycle 0.
- Normal path:
  - Cycle 1 is PREP.
  - Cycles 2..WIDTH+1 are CALC.
  - Cycle WIDTH+2 is FIX.
  - Cycle WIDTH+3 is DONE.
  - done=1 in cycle WIDTH+3 only (cycle 35 for WIDTH=32).
- Divide-by-zero path: PREP in cycle 1, DONE in cycle 2. done=1 and div_zero=1 in cycle 2.
- busy=1 from cycle 1 through the cycle before DONE, and 0 in the DONE cycle. The earliest next accept is cycle WIDTH+4.
- hi and lo are registered outputs. They change only on the edge entering DONE, or on reset.
- Reset values: busy=0, done=0, hi=0, lo=0, div_zero=0, state IDLE.
- There are no combinational paths from inputs to outputs.

## Test plan

All scenarios use WIDTH=32.

- Signed mult: op=00, a=FFFFFFFD, b=00000005 -> done only in cycle 35, hi=FFFFFFFF, lo=FFFFFFF1, busy=1 in cycles 1-34.
- Unsigned mult: op=01, a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Repeating with op=00 -> hi=00000000, lo=00000001.
- Signed/unsigned div:
  - op=10, a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
  - op=11, same operands -> lo=7FFFFFFC, hi=00000001.
  - op=10, a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div_zero=0.
- Divide by zero: preload hi/lo via 3*4 (hi=0, lo=C), then op=10, a=5, b=0 -> done in cycle 2, div_zero=1, hi=0, lo=C. The next accepted start clears div_zero.
- Handshake:
  - Pulse start again at cycles 5 and 35 with different operands -> both ignored, exactly one done.
  - Change a/b in cycle 3 -> result reflects the operands sampled in cycle 0.
- Reset mid-operation: start at cycle 0, reset=1 in cycle 10 -> from cycle 11 busy=0, hi=lo=0, and no done pulse for 40 cycles. A new start then completes normally.

Source files
------------

// File: rtl/seq_muldiv_unit.sv
// Multicycle signed/unsigned multiply and restoring divide for the Hi/Lo path.
// Latency WIDTH+4 cycles from accept to done (3 on divide-by-zero); start is ignored unless idle.
module seq_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_div_zero;

  logic               w_is_div;
  logic               w_signed;
  logic               w_b_zero;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
  logic               w_busy;
  logic               w_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_b_zero = (r_b == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_PREP;
      S_PREP: w_next = (w_is_div && w_b_zero) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_PREP, S_CALC, S_FIX: w_busy = 1'b1;
      S_DONE:                w_done = 1'b1;
      default: ;
    endcase
  end

  assign w_neg_a = w_signed & r_a[WIDTH-1];
  assign w_neg_b = w_signed & r_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -r_a : r_a;
  assign w_mag_b = w_neg_b ? -r_b : r_b;

  // Multiply: multiplier sits in acc_lo and shifts out as the product shifts in.
  assign w_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);

  // Divide: partial remainder needs one extra bit before the trial subtract.
  assign w_rem_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;

  assign w_prod = {r_acc_hi, r_acc_lo};

  always_comb begin
    w_fix_hi = r_acc_hi;
    w_fix_lo = r_acc_lo;
    if (w_is_div) begin
      w_fix_lo = (r_sign_a ^ r_sign_b) ? -r_acc_lo : r_acc_lo;
      w_fix_hi = r_sign_a ? -r_acc_hi : r_acc_hi;
    end else if (r_sign_a ^ r_sign_b) begin
      {w_fix_hi, w_fix_lo} = -w_prod;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_cnt      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_op       <= i_op;
          r_a        <= i_a;
          r_b        <= i_b;
          r_div_zero <= 1'b0;
        end
        S_PREP: begin
          r_sign_a <= w_neg_a;
          r_sign_b <= w_neg_b;
          r_b      <= w_mag_b;
          r_acc_hi <= '0;
          r_acc_lo <= w_mag_a;
          r_cnt    <= CW'(WIDTH);
          if (w_is_div && w_b_zero) r_div_zero <= 1'b1;
        end
        S_CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_is_div) begin
            r_acc_hi <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
          end else begin
            r_acc_hi <= w_sum[WIDTH:1];
            r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = w_busy;
  assign o_done     = w_done;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Bench for seq_muldiv_unit at WIDTH=32: directed vectors plus random ops against an arithmetic model.
module tb_seq_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks = 0;
  int failures = 0;

  logic        busy_log [64];
  logic        done_log [64];
  logic        dz_log   [64];
  logic [31:0] hi_log   [64];
  logic [31:0] lo_log   [64];
  int          n_done;
  int          done_cyc;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  seq_muldiv_unit #(.WIDTH(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo), .o_div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] mop, input logic [31:0] ma, mb,
                                input logic [31:0] ph, pl,
                                output logic [31:0] eh, el, output logic edz);
    longint          sp;
    logic [63:0]     up;
    int              sa, sb;
    eh = ph; el = pl; edz = 1'b0;
    case (mop)
      2'b00: begin sp = longint'($signed(ma)) * longint'($signed(mb)); {eh, el} = sp; end
      2'b01: begin up = {32'h0, ma} * {32'h0, mb}; {eh, el} = up; end
      2'b10: begin
        sa = $signed(ma); sb = $signed(mb);
        if (sb == 0) edz = 1'b1;
        else if (ma == 32'h80000000 && sb == -1) begin el = ma; eh = '0; end
        else begin el = sa / sb; eh = sa % sb; end
      end
      default: begin
        if (mb == 0) edz = 1'b1;
        else begin el = ma / mb; eh = ma % mb; end
      end
    endcase
  endfunction

  // Issues one start in cycle 0, optional extra start pulses / operand change / reset, logs n cycles.
  task automatic drive(input logic [1:0] op_i, input logic [31:0] a_i, b_i, input int n,
                       input int p1, input int p2, input int chg, input int rst_c);
    for (int c = 0; c < 64; c++) begin
      busy_log[c] = 1'bx; done_log[c] = 1'bx; dz_log[c] = 1'bx;
      hi_log[c] = 'x; lo_log[c] = 'x;
    end
    n_done = 0;
    done_cyc = -1;
    @(posedge clk); #1;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      start = (c == 0) || (c == p1) || (c == p2);
      reset = (c == rst_c);
      if (c == 0) begin op = op_i; a = a_i; b = b_i; end
      if (c == p1 || c == p2) begin op = 2'b10; a = $urandom; b = $urandom | 32'h1; end
      if (c == chg) begin a = ~a; b = b + 32'd7; end
      @(negedge clk);
      busy_log[c] = busy; done_log[c] = done; dz_log[c] = div_zero;
      hi_log[c] = hi; lo_log[c] = lo;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] res_hi();
    return (done_cyc >= 0) ? hi_log[done_cyc] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] res_lo();
    return (done_cyc >= 0) ? lo_log[done_cyc] : 32'hxxxxxxxx;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult_signed();
    int bad = 0;
    drive(2'b00, 32'hFFFFFFFD, 32'h5, 40, -1, -1, -1, -1);
    checks++; if (done_cyc != 35) begin failures++; $display("FAIL smul_done_cycle got=%0d exp=35", done_cyc); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL smul_done_count got=%0d exp=1", n_done); end
    checks++; if (res_hi() !== 32'hFFFFFFFF) begin failures++; $display("FAIL smul_hi got=%h exp=ffffffff", res_hi()); end
    checks++; if (res_lo() !== 32'hFFFFFFF1) begin failures++; $display("FAIL smul_lo got=%h exp=fffffff1", res_lo()); end
    for (int c = 0; c < 40; c++)
      if (busy_log[c] !== ((c >= 1 && c <= 34) ? 1'b1 : 1'b0)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL smul_busy_window got=%0d_bad_cycles exp=0", bad); end
    checks++; if (lo_log[34] !== m_lo) begin failures++; $display("FAIL smul_lo_held got=%h exp=%h", lo_log[34], m_lo); end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFF1;
  endtask

  task automatic test_mult_unsigned();
    drive(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 40, -1, -1, -1, -1);
    checks++; if (res_hi() !== 32'hFFFFFFFE) begin failures++; $display("FAIL umul_hi got=%h exp=fffffffe", res_hi()); end
    checks++; if (res_lo() !== 32'h00000001) begin failures++; $display("FAIL umul_lo got=%h exp=00000001", res_lo()); end
    drive(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 40, -1, -1, -1, -1);
    checks++; if (res_hi() !== 32'h00000000) begin failures++; $display("FAIL smul_m1_hi got=%h exp=00000000", res_hi()); end
    checks++; if (res_lo() !== 32'h00000001) begin failures++; $display("FAIL smul_m1_lo got=%h exp=00000001", res_lo()); end
    m_hi = 32'h0; m_lo = 32'h1;
  endtask

  task automatic test_div();
    drive(2'b10, 32'hFFFFFFF9, 32'h2, 40, -1, -1, -1, -1);
    checks++; if (res_lo() !== 32'hFFFFFFFD) begin failures++; $display("FAIL sdiv_lo got=%h exp=fffffffd", res_lo()); end
    checks++; if (res_hi() !== 32'hFFFFFFFF) begin failures++; $display("FAIL sdiv_hi got=%h exp=ffffffff", res_hi()); end
    drive(2'b11, 32'hFFFFFFF9, 32'h2, 40, -1, -1, -1, -1);
    checks++; if (res_lo() !== 32'h7FFFFFFC) begin failures++; $display("FAIL udiv_lo got=%h exp=7ffffffc", res_lo()); end
    checks++; if (res_hi() !== 32'h00000001) begin failures++; $display("FAIL udiv_hi got=%h exp=00000001", res_hi()); end
    drive(2'b10, 32'h80000000, 32'hFFFFFFFF, 40, -1, -1, -1, -1);
    checks++; if (res_lo() !== 32'h80000000) begin failures++; $display("FAIL sdiv_min_lo got=%h exp=80000000", res_lo()); end
    checks++; if (res_hi() !== 32'h00000000) begin failures++; $display("FAIL sdiv_min_hi got=%h exp=00000000", res_hi()); end
    checks++; if (dz_log[35] !== 1'b0) begin failures++; $display("FAIL sdiv_min_dz got=%b exp=0", dz_log[35]); end
    m_hi = 32'h0; m_lo = 32'h80000000;
  endtask

  task automatic test_div_zero();
    drive(2'b01, 32'd3, 32'd4, 40, -1, -1, -1, -1);
    checks++; if (res_lo() !== 32'hC) begin failures++; $display("FAIL preload_lo got=%h exp=0000000c", res_lo()); end
    drive(2'b10, 32'd5, 32'd0, 8, -1, -1, -1, -1);
    checks++; if (done_cyc != 2) begin failures++; $display("FAIL dz_done_cycle got=%0d exp=2", done_cyc); end
    checks++; if (dz_log[2] !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", dz_log[2]); end
    checks++; if (hi_log[2] !== 32'h0) begin failures++; $display("FAIL dz_hi_kept got=%h exp=00000000", hi_log[2]); end
    checks++; if (lo_log[2] !== 32'hC) begin failures++; $display("FAIL dz_lo_kept got=%h exp=0000000c", lo_log[2]); end
    checks++; if (busy_log[1] !== 1'b1 || busy_log[2] !== 1'b0) begin
      failures++; $display("FAIL dz_busy got=%b%b exp=10", busy_log[1], busy_log[2]);
    end
    checks++; if (dz_log[7] !== 1'b1) begin failures++; $display("FAIL dz_flag_hold got=%b exp=1", dz_log[7]); end
    drive(2'b01, 32'd2, 32'd3, 40, -1, -1, -1, -1);
    checks++; if (dz_log[1] !== 1'b0) begin failures++; $display("FAIL dz_clear_on_start got=%b exp=0", dz_log[1]); end
    checks++; if (res_lo() !== 32'd6) begin failures++; $display("FAIL after_dz_lo got=%h exp=00000006", res_lo()); end
    m_hi = 32'h0; m_lo = 32'd6;
  endtask

  task automatic test_handshake();
    logic [31:0] eh, el;
    logic        edz;
    logic [31:0] ta, tb;
    ta = $urandom; tb = $urandom;
    model(2'b01, ta, tb, m_hi, m_lo, eh, el, edz);
    drive(2'b01, ta, tb, 40, 5, 35, 3, -1);
    checks++; if (n_done != 1) begin failures++; $display("FAIL hs_done_count got=%0d exp=1", n_done); end
    checks++; if (done_cyc != 35) begin failures++; $display("FAIL hs_done_cycle got=%0d exp=35", done_cyc); end
    checks++; if (res_hi() !== eh) begin failures++; $display("FAIL hs_hi got=%h exp=%h", res_hi(), eh); end
    checks++; if (res_lo() !== el) begin failures++; $display("FAIL hs_lo got=%h exp=%h", res_lo(), el); end
    checks++; if (busy_log[36] !== 1'b0 || busy_log[39] !== 1'b0) begin
      failures++; $display("FAIL hs_done_cycle_start_ignored got=%b%b exp=00", busy_log[36], busy_log[39]);
    end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_reset_mid();
    logic [31:0] eh, el;
    logic        edz;
    logic [31:0] ta, tb;
    int          bad = 0;
    drive(2'b00, $urandom, $urandom, 60, -1, -1, -1, 10);
    for (int c = 11; c < 60; c++) if (busy_log[c] !== 1'b0) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rst_busy got=%0d_busy_cycles exp=0", bad); end
    checks++; if (hi_log[11] !== 32'h0 || lo_log[11] !== 32'h0) begin
      failures++; $display("FAIL rst_hilo got=%h_%h exp=0_0", hi_log[11], lo_log[11]);
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", n_done); end
    m_hi = '0; m_lo = '0;
    ta = $urandom; tb = $urandom;
    model(2'b00, ta, tb, m_hi, m_lo, eh, el, edz);
    drive(2'b00, ta, tb, 40, -1, -1, -1, -1);
    checks++; if (done_cyc != 35) begin failures++; $display("FAIL rst_after_cycle got=%0d exp=35", done_cyc); end
    checks++; if (res_hi() !== eh || res_lo() !== el) begin
      failures++; $display("FAIL rst_after_result got=%h_%h exp=%h_%h", res_hi(), res_lo(), eh, el);
    end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_random();
    logic [31:0] eh, el, ta, tb;
    logic        edz;
    logic [1:0]  top;
    int          exp_cyc;
    for (int i = 0; i < 40; i++) begin
      top = 2'($urandom_range(0, 3));
      ta = $urandom;
      tb = $urandom;
      case ($urandom_range(0, 7))
        0: tb = 32'h0;
        1: tb = 32'($urandom_range(1, 9));
        2: tb = 32'hFFFFFFFF;
        3: ta = 32'h80000000;
        default: ;
      endcase
      model(top, ta, tb, m_hi, m_lo, eh, el, edz);
      exp_cyc = edz ? 2 : 35;
      drive(top, ta, tb, 40, -1, -1, -1, -1);
      checks++; if (done_cyc != exp_cyc) begin
        failures++; $display("FAIL rnd%0d_cycle op=%b got=%0d exp=%0d", i, top, done_cyc, exp_cyc);
      end
      checks++; if (res_hi() !== eh || res_lo() !== el || dz_log[exp_cyc] !== edz) begin
        failures++;
        $display("FAIL rnd%0d_result op=%b a=%h b=%h got=%h_%h_%b exp=%h_%h_%b",
                 i, top, ta, tb, res_hi(), res_lo(), dz_log[exp_cyc], eh, el, edz);
      end
      m_hi = eh; m_lo = el;
    end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_mult_unsigned();
    test_div();
    test_div_zero();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
